// File: rtl/instr_encoder.sv
// instr_encoder: packs RV64 instruction fields into 32-bit words, flags range/alignment errors, buffers results in a DEPTH-entry valid/ready FIFO.
// Ports: clk, reset (sync, active-high); request side in_valid/in_ready with in_fmt, in_opcode, in_func3,
// in_func7, in_rd, in_rs1, in_rs2, in_imm; output side out_valid/out_ready with out_instr, out_err (FIFO head);
// err_cnt is a saturating count of accepted erroneous requests.
module instr_encoder #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_func3,
  input  logic [6:0]       in_func7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic signed [31:0] s;
  logic               is_shift;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic [32:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        cnt;
  logic               push, pop;
  always_comb begin
    s = $signed(in_imm);
    is_shift = (in_opcode == 7'b0010011 || in_opcode == 7'b0011011) && (in_func3 == 3'b001 || in_func3 == 3'b101);
    enc_word = '0;
    enc_err = 1'b0;
    case (in_fmt)
      3'd0: enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
      3'd1: begin
        enc_word = is_shift ? {in_func7[6:1], in_imm[5:0], in_rs1, in_func3, in_rd, in_opcode}
                            : {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
        enc_err = is_shift ? (s < 0 || s > 63) : (s < -2048 || s > 2047);
      end
      3'd2: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
        enc_err = s < -2048 || s > 2047;
      end
      3'd3: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3, in_imm[4:1], in_imm[11], in_opcode};
        enc_err = s < -4096 || s > 4094 || in_imm[0];
      end
      3'd4: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err = in_imm[11:0] != 12'd0;
      end
      3'd5: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err = s < -32'sd1048576 || s > 32'sd1048574 || in_imm[0];
      end
      default: enc_err = 1'b1;
    endcase
  end
  assign out_valid = cnt != '0;
  assign in_ready  = cnt != (AW+1)'(DEPTH) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // When empty, the slot just behind rd_ptr is the last popped entry and stays untouched until the
  // FIFO is non-empty again, so it provides the held output value (cleared by reset).
  assign {out_err, out_instr} = out_valid ? mem[rd_ptr] : mem[rd_ptr - AW'(1)];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_err, enc_word};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (push && enc_err && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table vectors, hand-written FIFO/reset sequences and randomized traffic against a field-arithmetic model.
module tb_instr_encoder;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
  logic [2:0]  in_fmt = 0, in_func3 = 0;
  logic [6:0]  in_opcode = 0, in_func7 = 0;
  logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_instr;
  logic [7:0]  err_cnt;
  int n_vec = 0, n_bad = 0;

  instr_encoder #(.DEPTH(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [2:0] fmt; bit [6:0] op; bit [2:0] f3; bit [6:0] f7;
    bit [4:0] rd; bit [4:0] rs1; bit [4:0] rs2; bit [31:0] imm;
    bit [31:0] w; bit e;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_func3 = v.f3; in_func7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
  endtask

  // Reference: place each field by shift-and-mask arithmetic, range checks on the sign-extended value.
  function automatic void ref_enc(input bit [2:0] fmt, input bit [31:0] op, input bit [31:0] f3,
      input bit [31:0] f7, input bit [31:0] rd, input bit [31:0] rs1, input bit [31:0] rs2,
      input bit [31:0] imm, output bit [31:0] w, output bit e);
    longint sv = longint'($signed(imm));
    bit [31:0] base = (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    bit shift = (op == 32'h13 || op == 32'h1B) && (f3 == 1 || f3 == 5);
    w = 0; e = 0;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | base;
      1: if (shift) begin
           w = ((f7 >> 1) << 26) | ((imm & 63) << 20) | base; e = sv < 0 || sv > 63;
         end else begin
           w = ((imm & 32'hFFF) << 20) | base; e = sv < -2048 || sv > 2047;
         end
      2: begin
           w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 31) << 7) | op;
           e = sv < -2048 || sv > 2047;
         end
      3: begin
           w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
           e = sv < -4096 || sv > 4094 || (sv % 2) != 0;
         end
      4: begin w = (imm & 32'hFFFFF000) | (rd << 7) | op; e = (imm & 32'hFFF) != 0; end
      5: begin
           w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
             | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
           e = sv < -1048576 || sv > 1048574 || (sv % 2) != 0;
         end
      default: e = 1;
    endcase
  endfunction

  initial begin
    bit [32:0] q[$];
    bit [32:0] last;
    bit [31:0] w, r;
    bit e, exp_ready;
    int mcnt, ecnt;
    tbl = '{
      '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0},
      '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0},
      '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0},
      '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0},
      '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0},
      '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096,     32'h00000093, 1'b1},
      '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b1},
      '{3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3,        32'h00309093, 1'b0},
      '{3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3,        32'h4030D093, 1'b0},
      '{3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd64,       32'h00009093, 1'b1},
      '{3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00000000, 1'b1},
      '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h123452B7, 1'b1},
      '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF000, 32'h80000063, 1'b0},
      '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00001000, 32'h80000063, 1'b1},
      '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0},
      '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h800000EF, 1'b1},
      '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0},
      '{3'd1, 7'h1B, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd63,       32'h03F0909B, 1'b0},
      '{3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 32'h03F09093, 1'b1}
    };
    // reset state
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    // table vectors, one at a time into an empty FIFO
    ecnt = 0;
    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k]); in_valid = 1; out_ready = 0;
      #1 chk($sformatf("tbl%0d_pre_valid", k), out_valid, 0);
      @(negedge clk);
      in_valid = 0; out_ready = 1;
      if (tbl[k].e) ecnt++;
      #1;
      chk($sformatf("tbl%0d_valid", k), out_valid, 1);
      chk($sformatf("tbl%0d_instr", k), out_instr, tbl[k].w);
      chk($sformatf("tbl%0d_err", k), out_err, tbl[k].e);
      chk($sformatf("tbl%0d_err_cnt", k), err_cnt, ecnt);
    end
    // err_cnt counts then saturates
    @(negedge clk);
    drive(tbl[10]); in_valid = 1; out_ready = 1;
    repeat (240) @(negedge clk);
    #1 chk("sat_count", err_cnt, ecnt + 240);
    repeat (20) @(negedge clk);
    #1 chk("sat_hold", err_cnt, 8'hFF);
    in_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1 chk("sat_reset", err_cnt, 0);
    // backpressure with DEPTH=2
    @(negedge clk);
    drive(tbl[0]); in_valid = 1; out_ready = 0;
    #1 chk("bp_ready_a", in_ready, 1);
    @(negedge clk);
    drive(tbl[1]);
    #1 chk("bp_ready_b", in_ready, 1);
    chk("bp_head_a0", out_instr, tbl[0].w);
    @(negedge clk);
    drive(tbl[2]);
    #1 chk("bp_full", in_ready, 0);
    @(negedge clk);
    #1 chk("bp_held", in_ready, 0);
    chk("bp_head_a1", out_instr, tbl[0].w);
    out_ready = 1;
    #1 chk("bp_ready_passthru", in_ready, 1);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #1 chk("bp_pushpop_full", in_ready, 0);
    chk("bp_head_b", out_instr, tbl[1].w);
    out_ready = 1;
    @(negedge clk);
    #1 chk("bp_head_c", out_instr, tbl[2].w);
    chk("bp_valid_c", out_valid, 1);
    @(negedge clk);
    #1 chk("bp_empty", out_valid, 0);
    chk("bp_hold", out_instr, tbl[2].w);
    out_ready = 0;
    // reset with two entries queued
    @(negedge clk);
    drive(tbl[5]); in_valid = 1;
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    in_valid = 0; reset = 1;
    #1 chk("mid_queued", out_valid, 1);
    @(negedge clk);
    reset = 0;
    #1 chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 1);
    chk("mid_err_cnt", err_cnt, 0);
    drive(tbl[3]); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    #1 chk("mid_push_valid", out_valid, 1);
    chk("mid_push_instr", out_instr, tbl[3].w);
    reset = 1;
    @(negedge clk);
    reset = 0;
    // randomized traffic against the queue model
    mcnt = 0; last = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_fmt = 3'($urandom_range(0, 7));
      case ($urandom % 3)
        0: in_opcode = 7'h13;
        1: in_opcode = 7'h1B;
        default: in_opcode = 7'($urandom);
      endcase
      in_func3 = 3'($urandom); in_func7 = 7'($urandom);
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      r = $urandom;
      case ($urandom % 5)
        0: in_imm = 32'($urandom_range(0, 100)) - 32'd50;
        1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: in_imm = r & 32'hFFFFF000;
        3: in_imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
        default: in_imm = r;
      endcase
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      #1;
      exp_ready = q.size() < 2 || out_ready;
      chk("rnd_in_ready", in_ready, exp_ready);
      chk("rnd_out_valid", out_valid, q.size() != 0);
      chk("rnd_err_cnt", err_cnt, mcnt);
      if (q.size() != 0) begin
        chk("rnd_instr", out_instr, q[0][31:0]);
        chk("rnd_err", out_err, q[0][32]);
      end else chk("rnd_hold", out_instr, last[31:0]);
      ref_enc(in_fmt, 32'(in_opcode), 32'(in_func3), 32'(in_func7), 32'(in_rd), 32'(in_rs1),
              32'(in_rs2), in_imm, w, e);
      @(posedge clk);
      if (q.size() != 0 && out_ready) last = q.pop_front();
      if (in_valid && exp_ready) begin
        q.push_back({e, w});
        if (e && mcnt < 255) mcnt++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
